// File: rtl/rv32m_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: radix-2 restoring division, one quotient bit per clock, MSB first.
// Optional macro DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC and finish one cycle after acceptance.
module rv32m_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_div,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done_div,
  output logic [WIDTH-1:0] f
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state, w_nextState;
  logic [2:0]       r_funct3;
  logic [WIDTH-1:0] r_a, r_b, r_divisor, r_quot, r_rem, r_f;
  logic [CW-1:0]    r_count;

  logic [WIDTH:0]   w_remShift, w_diff;
  logic             w_qBit;
  logic [WIDTH-1:0] w_aMag, w_bMag, w_nextQuot, w_nextRem, w_quotFix, w_remFix, w_result;

  // Codes other than DIV/REM/REMU fall through to DIVU behaviour.
  function automatic logic isSigned(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic isRem(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

  function automatic logic isSpecial(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                     input logic [WIDTH-1:0] y);
    return (y == '0) || (isSigned(op) && (x == MIN_NEG) && (y == '1));
  endfunction

  function automatic logic [WIDTH-1:0] specialResult(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                                     input logic [WIDTH-1:0] y);
    if (y == '0) return isRem(op) ? x : '1;
    return isRem(op) ? '0 : MIN_NEG;
  endfunction

  assign w_aMag = (isSigned(funct3) && a[WIDTH-1]) ? -a : a;
  assign w_bMag = (isSigned(funct3) && b[WIDTH-1]) ? -b : b;

  // Partial remainder always stays below the divisor, so only the shifted/trial value needs the extra bit.
  assign w_remShift = {r_rem, r_quot[WIDTH-1]};
  assign w_diff     = w_remShift - {1'b0, r_divisor};
  assign w_qBit     = ~w_diff[WIDTH];
  assign w_nextRem  = w_qBit ? w_diff[WIDTH-1:0] : w_remShift[WIDTH-1:0];
  assign w_nextQuot = {r_quot[WIDTH-2:0], w_qBit};

  assign w_quotFix = (isSigned(r_funct3) && (r_a[WIDTH-1] ^ r_b[WIDTH-1])) ? -w_nextQuot : w_nextQuot;
  assign w_remFix  = (isSigned(r_funct3) && r_a[WIDTH-1]) ? -w_nextRem : w_nextRem;
  assign w_result  = isSpecial(r_funct3, r_a, r_b) ? specialResult(r_funct3, r_a, r_b)
                   : (isRem(r_funct3) ? w_remFix : w_quotFix);

`ifdef DIV_EARLY_OUT_EN
  logic w_inSpecial;
  assign w_inSpecial = isSpecial(funct3, a, b);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    busy        = 1'b0;
    done_div    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_div) begin
`ifdef DIV_EARLY_OUT_EN
          if (w_inSpecial) w_nextState = DONE;
          else             w_nextState = CALC;
`else
          w_nextState = CALC;
`endif
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_count == LAST) w_nextState = DONE;
      end
      DONE: begin
        done_div    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_funct3  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_f       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_div) begin
            r_funct3  <= funct3;
            r_a       <= a;
            r_b       <= b;
            r_divisor <= w_bMag;
            r_quot    <= w_aMag;
            r_rem     <= '0;
            r_count   <= '0;
`ifdef DIV_EARLY_OUT_EN
            if (w_inSpecial) r_f <= specialResult(funct3, a, b);
`endif
          end
        end
        CALC: begin
          r_quot <= w_nextQuot;
          r_rem  <= w_nextRem;
          if (r_count == LAST) begin
            r_count <= '0;
            r_f     <= w_result;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign f = r_f;

endmodule

// File: tb/tb_rv32m_divider.sv
// Scoreboard bench for rv32m_divider: stimulus pushes expected result and timing, a negedge monitor pops and checks.
// Reference results come from plain SV signed/unsigned arithmetic plus the RISC-V special-case rules.
module tb_rv32m_divider;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_div;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a, b, f;
  logic             busy, done_div;

  typedef struct {
    logic [WIDTH-1:0] val;
    int               startCyc;
    int               doneCyc;
  } exp_t;

  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cycle      = 0;

  rv32m_divider #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start_div(start_div), .funct3(funct3),
    .a(a), .b(b), .busy(busy), .done_div(done_div), .f(f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic logic opSigned(input logic [2:0] op);
    return (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic opRem(input logic [2:0] op);
    return (op == 3'b110) || (op == 3'b111);
  endfunction

  function automatic logic [WIDTH-1:0] refModel(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    int sx, sy;
    sx = signed'(x);
    sy = signed'(y);
    if (y == 0) return opRem(op) ? x : 32'hFFFF_FFFF;
    if (opSigned(op) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
      return opRem(op) ? 32'h0 : 32'h8000_0000;
    if (opSigned(op)) return opRem(op) ? 32'(sx % sy) : 32'(sx / sy);
    return opRem(op) ? (x % y) : (x / y);
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [WIDTH-1:0] x,
                                    input logic [WIDTH-1:0] y);
`ifdef DIV_EARLY_OUT_EN
    if (y == 0 || (opSigned(op) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)) return 1;
`endif
    return LAT;
  endfunction

  function automatic logic [WIDTH-1:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic waitDrain(input int bound);
    for (int i = 0; i < bound && sbQueue.size() > 0; i++) @(negedge clk);
    if (sbQueue.size() > 0) begin
      checkOutput("drain timeout", 32'(sbQueue.size()), 32'h0);
      sbQueue.delete();
    end
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y);
    exp_t e;
    @(negedge clk);
    funct3    = op;
    a         = x;
    b         = y;
    start_div = 1'b1;
    e.val      = refModel(op, x, y);
    e.startCyc = cycle;
    e.doneCyc  = cycle + refLatency(op, x, y);
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    // Scramble inputs right after acceptance so any leak into the result shows up.
    start_div = 1'b0;
    a         = $urandom;
    b         = $urandom;
    funct3    = 3'($urandom_range(0, 7));
    waitDrain(LAT + 10);
  endtask

  // Monitor: checks busy against the pending operation's window and pops on every done_div.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (sbQueue.size() > 0)
          checkOutput("busy", 32'(busy),
                      32'(cycle > sbQueue[0].startCyc && cycle < sbQueue[0].doneCyc));
        if (done_div) begin
          if (sbQueue.size() == 0) begin
            checkOutput("spurious done_div", 32'(done_div), 32'h0);
          end else begin
            e = sbQueue.pop_front();
            checkOutput("f", f, e.val);
            checkOutput("done cycle", 32'(cycle), 32'(e.doneCyc));
          end
        end else if (sbQueue.size() > 0 && cycle >= sbQueue[0].doneCyc) begin
          checkOutput("done_div missing", 32'(done_div), 32'h1);
          void'(sbQueue.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    rst       = 1'b1;
    start_div = 1'b0;
    funct3    = 3'b000;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done_div", 32'(done_div), 32'h0);
    checkOutput("reset f", f, 32'h0);
    rst = 1'b0;

    applyStimulus(3'b101, 32'd100, 32'd7);
    applyStimulus(3'b111, 32'd100, 32'd7);
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(3'b101, 32'd5, 32'd0);
    applyStimulus(3'b110, 32'hFFFF_FFFB, 32'd0);
    applyStimulus(3'b100, 32'hFFFF_FFFB, 32'd0);

    // start_div held high through the first operation: it is ignored until IDLE, then restarts.
    @(negedge clk);
    funct3    = 3'b101;
    a         = 32'd50;
    b         = 32'd5;
    start_div = 1'b1;
    n         = cycle;
    e.val = 32'd10; e.startCyc = n;      e.doneCyc = n + LAT;
    sbQueue.push_back(e);
    e.val = 32'd3;  e.startCyc = n + 34; e.doneCyc = n + 34 + LAT;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    a = 32'd9;
    b = 32'd3;
    repeat (34) @(posedge clk);
    #1;
    start_div = 1'b0;
    waitDrain(2 * LAT + 10);

    // Reset pulse during iteration 10 must abort silently.
    @(negedge clk);
    funct3    = 3'b101;
    a         = 32'd1000;
    b         = 32'd3;
    start_div = 1'b1;
    @(posedge clk);
    #1;
    start_div = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort busy", 32'(busy), 32'h0);
    checkOutput("abort done_div", 32'(done_div), 32'h0);
    checkOutput("abort f", f, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    applyStimulus(3'b101, 32'd1000, 32'd3);

    for (int i = 0; i < 40; i++)
      applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rv32m_divider.md
RV32M_DIVIDER -- requirements
Module: rv32m_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width.
REQ-002 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port start_div  input  1: divide request; sampled only in IDLE.
REQ-005 SHALL have port funct3  input  3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU; other codes behave as DIVU.
REQ-006 SHALL have port a  input  WIDTH: dividend.
REQ-007 SHALL have port b  input  WIDTH: divisor.
REQ-008 SHALL have port busy  output  1: high while in CALC.
REQ-009 SHALL have port done_div  output  1: one-cycle result-valid pulse.
REQ-010 SHALL have port f  output  WIDTH: quotient or remainder; holds its value until the next DONE.

Function
REQ-011 SHALL implement states IDLE, CALC and DONE.
REQ-012 Transitions SHALL be:
  - IDLE->CALC when start_div=1.
  - CALC->DONE after exactly WIDTH iterations.
  - DONE->IDLE unconditionally.
REQ-013 On acceptance, SHALL latch funct3, a and b; input changes after acceptance SHALL NOT affect the result.
REQ-014 start_div SHALL be ignored in CALC and DONE; the requester deasserts it on seeing done_div, else a new operation starts the cycle after DONE.
REQ-015 CALC SHALL run radix-2 restoring division on unsigned magnitudes, one quotient bit per cycle, MSB first.
REQ-016 Magnitudes: |a| and |b| for DIV/REM; raw values for DIVU/REMU; |0x80000000| SHALL be 0x80000000 unsigned.
REQ-017 Sign fix, DIV: quotient negated (two's complement) iff sign(a)!=sign(b).
REQ-018 Sign fix, REM: remainder takes the sign of a.
REQ-019 Divide by zero (b=0) SHALL override the computed result: quotient = all ones; remainder = a, unmodified.
REQ-020 Signed overflow (DIV/REM, a=0x80000000, b=all ones) SHALL override the computed result: quotient = 0x80000000; remainder = 0.
REQ-021 Latency SHALL be: start_div sampled in cycle N, then CALC in cycles N+1..N+WIDTH, then DONE in cycle N+WIDTH+1.
REQ-022 In DONE, done_div SHALL be 1 and f SHALL carry the result in that same cycle; done_div SHALL be 0 in every other state.
REQ-023 Arithmetic SHALL use a WIDTH+1-bit partial remainder; there SHALL be no truncation loss for any operand pair.

Reset
REQ-024 rst=1 SHALL asynchronously force state IDLE, busy=0, done_div=0, f=0, iteration counter=0 and all operand/partial registers to 0.
REQ-025 Reset mid-CALC SHALL abort the operation with no done_div; the first start_div after reset release SHALL complete normally.

Configuration
REQ-026 Macro DIV_EARLY_OUT_EN SHALL control special-case timing.
  - Defined: divide-by-zero and signed-overflow operations SHALL skip CALC (IDLE->DONE), with done_div in cycle N+1.
  - Undefined: all operations SHALL take the full REQ-021 latency.
  - Results SHALL be identical either way.

Verification
REQ-027 DIVU a=100, b=7, start in cycle N -> busy high N+1..N+32, done_div=1 and f=14 in N+33 only; REMU same operands -> f=2.
REQ-028 DIV a=0xFFFFFFF9 (-7), b=2 -> f=0xFFFFFFFD; REM same operands -> f=0xFFFFFFFF.
REQ-029 DIV a=0x80000000, b=0xFFFFFFFF -> f=0x80000000; REM same operands -> f=0; done_div in N+1 with DIV_EARLY_OUT_EN defined, N+33 without.
REQ-030 DIVU a=5, b=0 -> f=0xFFFFFFFF; REM a=0xFFFFFFFB, b=0 -> f=0xFFFFFFFB; DIV a=0xFFFFFFFB, b=0 -> f=0xFFFFFFFF.
REQ-031 Reset mid-operation:
  - Stimulus: DIVU a=1000, b=3; rst pulsed during iteration 10.
  - Required: busy=0, done_div=0, f=0 immediately; no done_div afterwards.
  - Then DIVU a=1000, b=3 -> f=333 at the expected cycle.
REQ-032 Start ignored while busy:
  - Stimulus: DIVU a=50, b=5 accepted; then start_div=1 with a=9, b=3 held through CALC.
  - Required: first done_div gives f=10; since start_div remains high, a second operation starts in cycle N+34 and gives f=3 in cycle N+67.
